// File: rtl/circle_buf4.sv
// Triggered two-bank capture buffer: the write side records a sample stream
// around a trigger, the read side streams a completed bank out oldest-first.
module circle_buf4 #(
    parameter int aw = 6,
    parameter int dw = 16
) (
    input  logic          wclk,
    input  logic          reset,
    input  logic [dw-1:0] data_w,
    input  logic          data_gate_in,
    input  logic          stb_w,
    input  logic          trig_ext,
    input  logic          trig_internal_ena,
    input  logic [aw-1:0] trigger_location,
    output logic          full_flag,
    input  logic          stb_r,
    input  logic [aw-1:0] addr_r,
    output logic [dw-1:0] data_r,
    output logic          data_gate_out,
    output logic          empty_flag,
    input  logic          rewind
);
    localparam int depth = 2 ** (aw + 1);

    logic [dw-1:0] mem_q [depth];

    logic          w_bank_q, w_bank_d;
    logic          r_bank_q, r_bank_d;
    logic [aw-1:0] w_addr_q, w_addr_d;
    logic [aw-1:0] r_addr_q, r_addr_d;
    logic [aw-1:0] pre_cnt_q, pre_cnt_d;
    logic [aw-1:0] addr_start_q, addr_start_d;
    logic [aw-1:0] r_start_q, r_start_d;
    logic          triggered_q, triggered_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          gate_q, gate_d;
    logic [dw-1:0] data_r_q, data_r_d;

    logic          acc;
    logic          trig;
    logic          trig_ena;
    logic          bank_done;
    logic          swap;
    logic [aw-1:0] w_addr_inc;
    logic [aw-1:0] start_eff;
    logic [aw-1:0] rd_off;

    always_comb begin
        acc        = stb_w & data_gate_in & ~full_q;
        trig       = trig_internal_ena | trig_ext;
        trig_ena   = acc & trig & ~triggered_q & (pre_cnt_q == trigger_location);
        w_addr_inc = w_addr_q + aw'(1);
        // the trigger sample itself may close the bank when the pre-trigger depth is maximal
        start_eff  = trig_ena ? (w_addr_q - trigger_location) : addr_start_q;
        bank_done  = acc & (triggered_q | trig_ena) & (w_addr_inc == start_eff);
        swap       = (bank_done | full_q) & empty_q;

        w_bank_d     = w_bank_q;
        r_bank_d     = r_bank_q;
        w_addr_d     = w_addr_q;
        pre_cnt_d    = pre_cnt_q;
        addr_start_d = addr_start_q;
        r_start_d    = r_start_q;
        triggered_d  = triggered_q;
        full_d       = full_q;

        if (acc) begin
            w_addr_d  = w_addr_inc;
            pre_cnt_d = (pre_cnt_q < trigger_location) ? pre_cnt_q + aw'(1) : trigger_location;
            if (trig_ena) begin
                triggered_d  = 1'b1;
                addr_start_d = start_eff;
            end
            if (bank_done & ~empty_q) begin
                full_d = 1'b1;
            end
        end

        if (swap) begin
            r_bank_d    = w_bank_q;
            w_bank_d    = ~w_bank_q;
            r_start_d   = start_eff;
            w_addr_d    = '0;
            triggered_d = 1'b0;
            pre_cnt_d   = '0;
            full_d      = 1'b0;
        end

        r_addr_d = r_addr_q;
        empty_d  = empty_q;
        data_r_d = data_r_q;
        gate_d   = 1'b0;
        rd_off   = r_start_q + (stb_r ? r_addr_q : addr_r);

        if (rewind) begin
            r_addr_d = '0;
        end else if (stb_r) begin
            if (~empty_q) begin
                data_r_d = mem_q[{r_bank_q, rd_off}];
                gate_d   = 1'b1;
                r_addr_d = r_addr_q + aw'(1);
                if (r_addr_q == '1) begin
                    empty_d = 1'b1;
                end
            end
        end else begin
            data_r_d = mem_q[{r_bank_q, rd_off}];
        end

        // swap needs an empty read side, so it never collides with a sequential read
        if (swap) begin
            r_addr_d = '0;
            empty_d  = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        if (acc) begin
            mem_q[{w_bank_q, w_addr_q}] <= data_w;
        end
    end

    always_ff @(posedge wclk) begin
        if (reset) begin
            w_bank_q     <= 1'b0;
            r_bank_q     <= 1'b1;
            w_addr_q     <= '0;
            r_addr_q     <= '0;
            pre_cnt_q    <= '0;
            addr_start_q <= '0;
            r_start_q    <= '0;
            triggered_q  <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            gate_q       <= 1'b0;
            data_r_q     <= '0;
        end else begin
            w_bank_q     <= w_bank_d;
            r_bank_q     <= r_bank_d;
            w_addr_q     <= w_addr_d;
            r_addr_q     <= r_addr_d;
            pre_cnt_q    <= pre_cnt_d;
            addr_start_q <= addr_start_d;
            r_start_q    <= r_start_d;
            triggered_q  <= triggered_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            gate_q       <= gate_d;
            data_r_q     <= data_r_d;
        end
    end

    assign full_flag     = full_q;
    assign empty_flag    = empty_q;
    assign data_gate_out = gate_q;
    assign data_r        = data_r_q;
endmodule

// File: tb/tb_circle_buf4.sv
// Directed bench for circle_buf4: expected read words are queued as samples
// are accepted and popped whenever the buffer presents a gated read word.
module tb_circle_buf4;
    localparam int aw = 6;
    localparam int dw = 16;

    logic          wclk;
    logic          reset;
    logic [dw-1:0] data_w;
    logic          data_gate_in;
    logic          stb_w;
    logic          trig_ext;
    logic          trig_internal_ena;
    logic [aw-1:0] trigger_location;
    logic          full_flag;
    logic          stb_r;
    logic [aw-1:0] addr_r;
    logic [dw-1:0] data_r;
    logic          data_gate_out;
    logic          empty_flag;
    logic          rewind;

    circle_buf4 #(.aw(aw), .dw(dw)) dut (
        .wclk              (wclk),
        .reset             (reset),
        .data_w            (data_w),
        .data_gate_in      (data_gate_in),
        .stb_w             (stb_w),
        .trig_ext          (trig_ext),
        .trig_internal_ena (trig_internal_ena),
        .trigger_location  (trigger_location),
        .full_flag         (full_flag),
        .stb_r             (stb_r),
        .addr_r            (addr_r),
        .data_r            (data_r),
        .data_gate_out     (data_gate_out),
        .empty_flag        (empty_flag),
        .rewind            (rewind)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int sb[$];
    int n_pass  = 0;
    int n_total = 0;
    int n_pop   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // one clock; outputs are inspected at the falling edge, inputs change after
    task automatic tick();
        int exp;
        @(posedge wclk);
        @(negedge wclk);
        if (data_gate_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_gate", 32'(data_gate_out), 32'd0);
            end else begin
                exp = sb.pop_front();
                check("stream", 32'(data_r), 32'(exp));
                n_pop++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int val;
        int n_acc;
        int cyc;
        int base;
        int pop0;
        bit saw_clear;

        reset = 1'b1; data_w = '0; data_gate_in = 1'b0; stb_w = 1'b0;
        trig_ext = 1'b0; trig_internal_ena = 1'b1; trigger_location = '0;
        stb_r = 1'b0; addr_r = '0; rewind = 1'b0;

        tick(); tick(); tick();
        check("rst_empty", 32'(empty_flag), 32'd1);
        check("rst_full", 32'(full_flag), 32'd0);
        check("rst_gate", 32'(data_gate_out), 32'd0);
        check("rst_data", 32'(data_r), 32'd0);
        reset = 1'b0;

        // continuous stream, internal trigger, sparse accepts, reader always on
        stb_r = 1'b1; val = 0; n_acc = 0; cyc = 0;
        while (n_acc < 640 && cyc < 5000) begin
            case (cyc % 5)
                0: begin stb_w = 1'b1; data_gate_in = 1'b1; end
                2: begin stb_w = 1'b1; data_gate_in = 1'b0; end
                3: begin stb_w = 1'b0; data_gate_in = 1'b1; end
                default: begin stb_w = 1'b0; data_gate_in = 1'b0; end
            endcase
            data_w = 16'(val);
            if (stb_w && data_gate_in && !full_flag) begin
                sb.push_back(val); val++; n_acc++;
            end
            tick(); cyc++;
        end
        check("t2_accepts", 32'(n_acc), 32'd640);
        stb_w = 1'b0; data_gate_in = 1'b0;
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
        check("t2_drain", 32'(sb.size()), 32'd0);
        check("t2_pops", 32'(n_pop), 32'd640);

        // reader stalled: one bank swaps, the next fills, then writes stall
        stb_r = 1'b0; base = val; n_acc = 0;
        for (int i = 0; i < 200; i++) begin
            stb_w = 1'b1; data_gate_in = 1'b1; data_w = 16'(val);
            if (!full_flag) begin sb.push_back(val); val++; n_acc++; end
            tick();
        end
        check("t3_stall_accepts", 32'(n_acc), 32'd128);
        check("t3_full", 32'(full_flag), 32'd1);
        check("t3_not_empty", 32'(empty_flag), 32'd0);
        stb_w = 1'b0; addr_r = 6'd5;
        tick();
        check("t3_random_read", 32'(data_r), 32'(base + 5));
        check("t3_random_gate", 32'(data_gate_out), 32'd0);
        addr_r = 6'd0;

        stb_r = 1'b1; saw_clear = 1'b0; cyc = 0;
        while (n_acc < 192 && cyc < 600) begin
            stb_w = 1'b1; data_gate_in = 1'b1; data_w = 16'(val);
            if (!full_flag) begin sb.push_back(val); val++; n_acc++; end
            tick(); cyc++;
            if (full_flag === 1'b0) saw_clear = 1'b1;
        end
        check("t3_resume_accepts", 32'(n_acc), 32'd192);
        check("t3_full_cleared", 32'(saw_clear), 32'd1);
        stb_w = 1'b0;
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
        check("t3_drain", 32'(sb.size()), 32'd0);
        check("t3_end_empty", 32'(empty_flag), 32'd1);

        // external trigger pulse at sample 100, 20 pre-trigger samples
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        sb.delete();
        trig_internal_ena = 1'b0; trigger_location = 6'd20; stb_r = 1'b1;
        for (int k = 80; k < 144; k++) sb.push_back(k);
        for (int i = 0; i < 200; i++) begin
            stb_w = 1'b1; data_gate_in = 1'b1; data_w = 16'(i);
            trig_ext = (i == 100);
            tick();
        end
        stb_w = 1'b0; trig_ext = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        check("t4_drain", 32'(sb.size()), 32'd0);
        check("t4_empty", 32'(empty_flag), 32'd1);
        check("t4_full", 32'(full_flag), 32'd0);

        // trigger held high from reset: fires on the 21st sample, bank = 0..63
        reset = 1'b1; trig_ext = 1'b1; stb_r = 1'b0; tick(); tick(); reset = 1'b0;
        sb.delete();
        for (int i = 0; i < 64; i++) begin
            stb_w = 1'b1; data_gate_in = 1'b1; data_w = 16'(i);
            tick();
        end
        stb_w = 1'b0;
        tick();
        check("t5_bank_ready", 32'(empty_flag), 32'd0);
        for (int k = 0; k < 10; k++) sb.push_back(k);
        stb_r = 1'b1;
        repeat (10) tick();
        rewind = 1'b1;
        tick();
        check("t5_rewind_gate", 32'(data_gate_out), 32'd0);
        rewind = 1'b0;
        for (int k = 0; k < 64; k++) sb.push_back(k);
        repeat (63) tick();
        check("t5_not_yet_empty", 32'(empty_flag), 32'd0);
        tick();
        check("t5_empty_after_64", 32'(empty_flag), 32'd1);
        check("t5_drain", 32'(sb.size()), 32'd0);

        // reset in the middle of a readout with the write side stalled
        reset = 1'b1; trig_ext = 1'b0; trig_internal_ena = 1'b1;
        trigger_location = '0; stb_r = 1'b0; tick(); tick(); reset = 1'b0;
        sb.delete();
        val = 0;
        for (int i = 0; i < 150; i++) begin
            stb_w = 1'b1; data_gate_in = 1'b1; data_w = 16'(val);
            if (!full_flag) begin sb.push_back(val); val++; end
            tick();
        end
        check("t6_full_before_reset", 32'(full_flag), 32'd1);
        stb_w = 1'b0; stb_r = 1'b1; pop0 = n_pop;
        for (int i = 0; i < 20 && (n_pop - pop0) < 10; i++) tick();
        check("t6_reads_before_reset", 32'(n_pop - pop0), 32'd10);
        reset = 1'b1;
        tick();
        check("t6_rst_empty", 32'(empty_flag), 32'd1);
        check("t6_rst_full", 32'(full_flag), 32'd0);
        check("t6_rst_gate", 32'(data_gate_out), 32'd0);
        check("t6_rst_data", 32'(data_r), 32'd0);
        reset = 1'b0;
        sb.delete();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
